// File: rtl/note_sequencer_if.sv
// Record/playback bus for note_sequencer. With NOTE_SEQ_TRANSPOSE_EN defined it also
// carries octave_shift.
interface note_sequencer_if #(
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned OCT_W  = 2,
  parameter int unsigned ADDR_W = 4
) ();
  logic [NOTE_W-1:0]       note_data;
  logic [OCT_W-1:0]        octave_data;
  logic                    ld_note;
  logic                    ld_play;
  logic                    tick;
  logic                    loop_en;
  logic                    clear;
`ifdef NOTE_SEQ_TRANSPOSE_EN
  logic [OCT_W-1:0]        octave_shift;
`endif
  logic [OCT_W+NOTE_W-1:0] play_entry;
  logic                    play_valid;
  logic [ADDR_W:0]         count;
  logic                    full;
  logic                    overflow;

`ifdef NOTE_SEQ_TRANSPOSE_EN
  modport master (
    output note_data, octave_data, ld_note, ld_play, tick, loop_en, clear, octave_shift,
    input  play_entry, play_valid, count, full, overflow
  );
  modport slave (
    input  note_data, octave_data, ld_note, ld_play, tick, loop_en, clear, octave_shift,
    output play_entry, play_valid, count, full, overflow
  );
`else
  modport master (
    output note_data, octave_data, ld_note, ld_play, tick, loop_en, clear,
    input  play_entry, play_valid, count, full, overflow
  );
  modport slave (
    input  note_data, octave_data, ld_note, ld_play, tick, loop_en, clear,
    output play_entry, play_valid, count, full, overflow
  );
`endif
endinterface

// File: rtl/note_sequencer.sv
// Note record/playback buffer: records {octave, note} on ld_note edges, plays one per tick.
// Optional NOTE_SEQ_TRANSPOSE_EN: saturating octave_shift applied to played entries.
module note_sequencer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned OCT_W  = 2
) (
  input logic            clk,
  input logic            reset,
  note_sequencer_if.slave bus
);
  localparam int unsigned EntryW = OCT_W + NOTE_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;
  logic [EntryW-1:0]   entry_q, entry_d;
  logic                ld_note_q, ld_play_q;
  logic [EntryW-1:0]   mem_q [DEPTH];

  logic                note_rise, play_rise, mem_we, is_full, rd_last;
  logic [ADDR_W-1:0]   rd_sel;
  logic [EntryW-1:0]   rd_word, rd_xf;

  assign note_rise = bus.ld_note & ~ld_note_q;
  assign play_rise = bus.ld_play & ~ld_play_q;
  assign is_full   = (count_q == DepthCnt);
  assign rd_last   = ({1'b0, rd_idx_q} == count_q - 1'b1);

  // Only two entries are ever loaded: the next one while playing, otherwise entry 0.
  assign rd_sel  = (state_q == StPlay && !rd_last) ? rd_idx_q + 1'b1 : '0;
  assign rd_word = mem_q[rd_sel];

`ifdef NOTE_SEQ_TRANSPOSE_EN
  logic [OCT_W:0] oct_sum;
  always_comb begin
    oct_sum = {1'b0, rd_word[EntryW-1:NOTE_W]} + {1'b0, bus.octave_shift};
    rd_xf   = rd_word;
    rd_xf[EntryW-1:NOTE_W] = oct_sum[OCT_W] ? '1 : oct_sum[OCT_W-1:0];
  end
`else
  assign rd_xf = rd_word;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_idx_d   = rd_idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    entry_d    = entry_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Starting playback wins over a same-cycle record or clear.
        if (play_rise && count_q != '0) begin
          state_d  = StPlay;
          rd_idx_d = '0;
          entry_d  = rd_xf;
          valid_d  = 1'b1;
        end else if (bus.clear) begin
          count_d    = '0;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else if (note_rise) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
      end
      StPlay: begin
        if (!bus.ld_play) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (bus.tick) begin
          if (!rd_last) begin
            rd_idx_d = rd_idx_q + 1'b1;
            entry_d  = rd_xf;
          end else if (bus.loop_en) begin
            rd_idx_d = '0;
            entry_d  = rd_xf;
          end else begin
            state_d = StDone;
            valid_d = 1'b0;
          end
        end
      end
      StDone: begin
        if (!bus.ld_play) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_idx_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      entry_q    <= '0;
      ld_note_q  <= 1'b0;
      ld_play_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_idx_q   <= rd_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      entry_q    <= entry_d;
      ld_note_q  <= bus.ld_note;
      ld_play_q  <= bus.ld_play;
    end
  end

  // Storage is deliberately not reset; count bounds what can be played.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {bus.octave_data, bus.note_data};
  end

  assign bus.play_entry = entry_q;
  assign bus.play_valid = valid_q;
  assign bus.count      = count_q;
  assign bus.full       = is_full;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_note_sequencer;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 2;
  localparam int unsigned EW     = OCT_W + NOTE_W;
  localparam int MIdle = 0, MPlay = 1, MDone = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  note_sequencer_if #(.NOTE_W(NOTE_W), .OCT_W(OCT_W), .ADDR_W(ADDR_W)) bus ();

  note_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .OCT_W(OCT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stored notes are simply a queue; playback is an index into it.
  logic [EW-1:0] mq[$];
  int            m_mode, m_idx;
  logic [EW-1:0] m_entry;
  bit            m_valid, m_ovf, m_ln, m_lp, m_nr, m_pr;

  function automatic logic [EW-1:0] xf(input logic [EW-1:0] e);
`ifdef NOTE_SEQ_TRANSPOSE_EN
    int o;
    o = int'(e[EW-1:NOTE_W]) + int'(bus.octave_shift);
    if (o > (1 << OCT_W) - 1) o = (1 << OCT_W) - 1;
    return {OCT_W'(o), e[NOTE_W-1:0]};
`else
    return e;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_mode = MIdle; m_idx = 0; m_entry = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_ln = 1'b0; m_lp = 1'b0;
    end else begin
      m_nr = bus.ld_note && !m_ln;
      m_pr = bus.ld_play && !m_lp;
      m_ln = bus.ld_note;
      m_lp = bus.ld_play;
      if (m_mode == MIdle) begin
        if (m_pr && mq.size() > 0) begin
          m_mode = MPlay; m_idx = 0; m_entry = xf(mq[0]); m_valid = 1'b1;
        end else if (bus.clear) begin
          mq.delete(); m_ovf = 1'b0;
        end else if (m_nr) begin
          if (mq.size() == DEPTH) m_ovf = 1'b1;
          else mq.push_back({bus.octave_data, bus.note_data});
        end
      end else if (m_mode == MPlay) begin
        if (!bus.ld_play) begin
          m_mode = MIdle; m_valid = 1'b0;
        end else if (bus.tick) begin
          if (m_idx + 1 < mq.size()) begin
            m_idx++; m_entry = xf(mq[m_idx]);
          end else if (bus.loop_en) begin
            m_idx = 0; m_entry = xf(mq[0]);
          end else begin
            m_mode = MDone; m_valid = 1'b0;
          end
        end
      end else begin
        if (!bus.ld_play) m_mode = MIdle;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("play_entry", int'(bus.play_entry), int'(m_entry));
      chk("play_valid", int'(bus.play_valid), int'(m_valid));
      chk("count", int'(bus.count), mq.size());
      chk("full", int'(bus.full), int'(mq.size() == DEPTH));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rec(input logic [OCT_W-1:0] oct, input logic [NOTE_W-1:0] nt);
    bus.octave_data = oct;
    bus.note_data   = nt;
    bus.ld_note     = 1'b1;
    step();
    bus.ld_note = 1'b0;
    step();
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic clear_pulse();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.note_data = '0; bus.octave_data = '0; bus.ld_note = 1'b0; bus.ld_play = 1'b0;
    bus.tick = 1'b0; bus.loop_en = 1'b0; bus.clear = 1'b0;
`ifdef NOTE_SEQ_TRANSPOSE_EN
    bus.octave_shift = '0;
`endif
    reset = 1'b1;
    step();
    step();
    chk("reset_count", int'(bus.count), 0);
    chk("reset_valid", int'(bus.play_valid), 0);
    chk("reset_entry", int'(bus.play_entry), 0);
    chk("reset_full", int'(bus.full), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    reset = 1'b0;
    chk_on = 1'b1;
    step();

    // Record three notes and play them one-shot.
    rec(1, 5); rec(2, 10); rec(0, 3);
    chk("t1_count", int'(bus.count), 3);
    chk("t1_full", int'(bus.full), 0);
    bus.ld_play = 1'b1;
    step();
    chk("t1_entry0", int'(bus.play_entry), 'h15);
    chk("t1_valid0", int'(bus.play_valid), 1);
    tick_pulse();
    chk("t1_entry1", int'(bus.play_entry), 'h2A);
    tick_pulse();
    chk("t1_entry2", int'(bus.play_entry), 'h03);
    tick_pulse();
    chk("t1_done_valid", int'(bus.play_valid), 0);
    chk("t1_done_entry", int'(bus.play_entry), 'h03);
    bus.ld_play = 1'b0;
    step();

    // A held strobe records exactly once.
    clear_pulse();
    bus.octave_data = 3; bus.note_data = 7; bus.ld_note = 1'b1;
    repeat (5) step();
    bus.ld_note = 1'b0;
    chk("t2_held_count", int'(bus.count), 1);
    step();
    rec(3, 7);
    chk("t2_second_count", int'(bus.count), 2);

    // Fill, overflow, clear.
    clear_pulse();
    for (int i = 0; i < 16; i++) rec(OCT_W'($urandom), NOTE_W'($urandom));
    chk("t3_full", int'(bus.full), 1);
    chk("t3_count16", int'(bus.count), 16);
    rec(1, 1);
    chk("t3_count_after17", int'(bus.count), 16);
    chk("t3_overflow", int'(bus.overflow), 1);
    clear_pulse();
    chk("t3_clr_count", int'(bus.count), 0);
    chk("t3_clr_full", int'(bus.full), 0);
    chk("t3_clr_overflow", int'(bus.overflow), 0);

    // Looping playback, then stop on a tick cycle.
    rec(1, 1); rec(2, 2);
    bus.loop_en = 1'b1;
    bus.ld_play = 1'b1;
    step();
    chk("t4_entry_a", int'(bus.play_entry), 'h11);
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      chk("t4_loop_entry", int'(bus.play_entry), (i % 2 == 0) ? 'h22 : 'h11);
      chk("t4_loop_valid", int'(bus.play_valid), 1);
    end
    bus.tick = 1'b1; bus.ld_play = 1'b0;
    step();
    bus.tick = 1'b0;
    chk("t4_stop_valid", int'(bus.play_valid), 0);
    chk("t4_stop_entry", int'(bus.play_entry), 'h22);
    bus.loop_en = 1'b0;
    step();

    // Empty buffer cannot play; record/clear ignored while playing.
    clear_pulse();
    bus.ld_play = 1'b1;
    step();
    chk("t5_empty_valid", int'(bus.play_valid), 0);
    bus.ld_play = 1'b0;
    step();
    rec(0, 1);
    bus.ld_play = 1'b1;
    step();
    chk("t5_play_valid", int'(bus.play_valid), 1);
    bus.ld_note = 1'b1; bus.clear = 1'b1;
    step();
    bus.ld_note = 1'b0; bus.clear = 1'b0;
    step();
    chk("t5_play_count", int'(bus.count), 1);
    chk("t5_play_entry", int'(bus.play_entry), 'h01);

    // Asynchronous reset mid-playback.
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", int'(bus.play_valid), 0);
    chk("t6_async_entry", int'(bus.play_entry), 0);
    chk("t6_async_count", int'(bus.count), 0);
    step();
    bus.ld_play = 1'b0;
    reset = 1'b0;
    step();

`ifdef NOTE_SEQ_TRANSPOSE_EN
    bus.octave_shift = 3;
    rec(2, 4);
    bus.ld_play = 1'b1;
    step();
    chk("t6_transpose", int'(bus.play_entry), 'h34);
    bus.ld_play = 1'b0;
    step();
    bus.octave_shift = 0;
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.ld_play = ~bus.ld_play;
      bus.ld_note     = ($urandom_range(0, 3) == 0);
      bus.tick        = ($urandom_range(0, 2) == 0);
      bus.clear       = ($urandom_range(0, 99) == 0);
      bus.loop_en     = 1'($urandom);
      bus.note_data   = NOTE_W'($urandom);
      bus.octave_data = OCT_W'($urandom);
`ifdef NOTE_SEQ_TRANSPOSE_EN
      bus.octave_shift = OCT_W'($urandom);
`endif
      step();
    end
    bus.ld_play = 1'b0; bus.ld_note = 1'b0; bus.tick = 1'b0; bus.clear = 1'b0;
    step();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Parametrised note record/playback buffer; successor to the single-track note datapath. Records {octave, note} entries into a DEPTH-entry register array on discrete load strobes, then plays them back one entry per tick, with one-shot or looping playback. Output entry feeds freq_select unchanged. Adds full/overflow status, clear, and loop mode.

Parameters:
DEPTH, 16, number of note entries; power of two, >= 2
ADDR_W, 4, index width; must equal log2(DEPTH)
NOTE_W, 4, note code width
OCT_W, 2, octave code width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
note_data  in  NOTE_W  note code to record
octave_data  in  OCT_W  octave code to record
ld_note  in  1  record strobe; rising edge writes one entry
ld_play  in  1  play request, level; rising edge starts playback, low returns to IDLE
tick  in  1  one-cycle pulse advancing playback to the next entry
loop_en  in  1  1 = wrap to entry 0 after last entry; sampled at each tick
clear  in  1  empties buffer and clears overflow (IDLE only)
play_entry  out  OCT_W+NOTE_W  current entry {octave, note}, registered
play_valid  out  1  play_entry is a live note
count  out  ADDR_W+1  number of stored entries, 0..DEPTH
full  out  1  count == DEPTH
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (async, high): state=IDLE, wr_ptr=0, rd_idx=0, count=0, overflow=0, play_entry=0, play_valid=0, ld_note/ld_play edge registers=0. Memory contents are not reset; unwritten entries are never played.
- Edge detect: ld_note_q and ld_play_q register the previous-cycle value; rise = in & ~q. A strobe held high for N cycles produces one event.
- FSM states: IDLE, PLAY, DONE.
- IDLE:
  - clear=1: count=0, wr_ptr=0, overflow=0. clear has priority over an ld_note rise on the same cycle, and that write is dropped.
  - ld_note rise, not full: mem[wr_ptr]<={octave_data,note_data}; wr_ptr+1 (wraps DEPTH-1 -> 0); count+1.
  - ld_note rise, full: no write, count unchanged, overflow<=1.
  - ld_play rise, count>0: go to PLAY; rd_idx<=0; play_entry<=mem[0]; play_valid<=1. These appear on the clock edge after the rise is detected.
  - ld_play rise, count==0: stay in IDLE; outputs unchanged.
  - ld_play rise and ld_note rise on the same cycle: playback wins; the write is dropped and overflow is unchanged.
- PLAY:
  - ld_note and clear are ignored.
  - ld_play==0: go to IDLE; play_valid<=0. This has priority over tick.
  - tick with rd_idx < count-1: rd_idx+1; play_entry<=mem[rd_idx+1].
  - tick with rd_idx == count-1 and loop_en=1: rd_idx<=0; play_entry<=mem[0]; play_valid stays 1.
  - tick with rd_idx == count-1 and loop_en=0: go to DONE; play_valid<=0; play_entry holds the last value.
- DONE: ld_play==0 -> IDLE. Nothing else has an effect.
- Latency: each event (ld_note, ld_play, tick) updates the outputs one clock after it is sampled.
- full and count are combinational from registered count.
- Async reset mid-PLAY forces all outputs to their reset values immediately.

Optional Feature:
NOTE_SEQ_TRANSPOSE_EN
- Defined: adds input port octave_shift [OCT_W-1:0].
  - Octave field of play_entry = min(stored_octave + octave_shift, 2^OCT_W-1), a saturating unsigned add.
  - Applied when play_entry is loaded; the note field is unchanged.
  - Stored memory is never modified.
- Undefined: port absent; play_entry is the stored entry verbatim.

Test Plan:
1. Reset; record note/octave (5,1),(10,2),(3,0) via single-cycle ld_note pulses -> count=3, full=0. Raise ld_play, pulse tick 2x -> play_entry 0x15, 0x2A, 0x03 with play_valid=1. Third tick with loop_en=0 -> DONE, play_valid=0.
2. Hold ld_note high 5 cycles with (7,3) -> exactly one write, count=1. Release and pulse again -> count=2.
3. Record 16 entries -> full=1, count=16. 17th pulse -> count=16, overflow=1. Pulse clear in IDLE -> count=0, full=0, overflow=0.
4. Two entries A=0x11, B=0x22, loop_en=1, ld_play high, 5 ticks -> play_entry A,B,A,B,A,B, play_valid constant 1. Drop ld_play on the same cycle as a tick -> IDLE, play_valid=0, no advance.
5. count=0, raise ld_play -> remains IDLE, play_valid=0. During PLAY pulse ld_note and clear -> count unchanged.
6. Assert reset between clock edges in PLAY -> play_valid=0, play_entry=0, count=0 without a clock edge. With NOTE_SEQ_TRANSPOSE_EN, stored (4,2) and octave_shift=3 -> play_entry=0x34.
